// File: rtl/return_address_stack.sv
// rtl/return_address_stack.sv - hardware call/return stack for the 8-bit sequencer
//
// Purpose: LIFO of return addresses.
//   PUSH stores an address. POP discards the top entry.
//   RETURN presents the top entry on top_val for the current cycle and pops it at the next edge.
//   Sticky overflow/underflow flags record misuse.
// Optional feature: define RAS_WRAP_EN to make the stack circular.
//   A PUSH while full then overwrites the oldest entry.
//   Without the macro, a PUSH while full is dropped.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stack_ctl    in   0=NOP 1=PUSH 2=POP 3=RETURN
//   stall        in   hold all stack state this cycle; err_clr still honoured
//   ret_addr_in  in   address pushed on PUSH
//   err_clr      in   clear sticky flags; a same-cycle new error wins
//   top_val      out  current top entry, 0 when empty
//   count        out  number of valid entries, 0..DEPTH
//   empty        out  count == 0
//   full         out  count == DEPTH
//   overflow     out  sticky: PUSH attempted while full
//   underflow    out  sticky: POP/RETURN attempted while empty
module return_address_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  stack_ctl,
    input  logic                        stall,
    input  logic [ADDR_W-1:0]           ret_addr_in,
    input  logic                        err_clr,
    output logic [ADDR_W-1:0]           top_val,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        full,
    output logic                        overflow,
    output logic                        underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

    localparam logic [1:0] CTL_PUSH   = 2'd1;
    localparam logic [1:0] CTL_POP    = 2'd2;
    localparam logic [1:0] CTL_RETURN = 2'd3;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp;      // next free slot; top entry lives at sp-1

    logic is_push, is_pop;
    logic do_push, do_pop;
    logic push_full, pop_empty;
    logic mem_we;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Top comes from registered state only; no path from stack_ctl.
    assign top_val = empty ? '0 : mem[sp - PTR_ONE];

    assign is_push   = !stall && (stack_ctl == CTL_PUSH);
    assign is_pop    = !stall && ((stack_ctl == CTL_POP) || (stack_ctl == CTL_RETURN));
    assign push_full = is_push && full;
    assign pop_empty = is_pop && empty;
    assign do_pop    = is_pop && !empty;

`ifdef RAS_WRAP_EN
    // Circular: a push always lands, overwriting the oldest slot when full.
    assign do_push = is_push;
`else
    assign do_push = is_push && !full;
`endif
    assign mem_we = do_push;

    // Storage holds no reset; contents are only observed through valid entries.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[sp] <= ret_addr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            count <= '0;
        end else if (do_push) begin
            sp <= sp + PTR_ONE;
            if (!full) begin
                count <= count + CNT_ONE;
            end
        end else if (do_pop) begin
            sp    <= sp - PTR_ONE;
            count <= count - CNT_ONE;
        end
    end

    // A new error in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  && !err_clr) || push_full;
            underflow <= (underflow && !err_clr) || pop_empty;
        end
    end
endmodule
